// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with sequential/jump/branch/call/return and a return-address stack.
// Optional macro PC_SEQUENCER_HALT_EN adds op 101 HALT and a sticky halted output.
module pc_sequencer #(
  parameter int WIDTH       = 16,
  parameter int STEP        = 1,
  parameter int RESET_VEC   = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_pc,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             take,
  output logic [WIDTH-1:0] pc_result,
  output logic             stack_full,
  output logic             stack_empty,
`ifdef PC_SEQUENCER_HALT_EN
  output logic             halted,
`endif
  output logic             stack_err
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VEC);
  localparam logic [DW-1:0]    FULL_W  = DW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100,
    OP_HALT   = 3'b101
  } op_e;

  logic [WIDTH-1:0] pc, pc_next;
  logic [DW-1:0]    depth, depth_next;
  logic             err, err_next;
  logic             push;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             active;

`ifdef PC_SEQUENCER_HALT_EN
  typedef enum logic {RUN, HALTED} state_e;
  state_e state, state_next;

  assign halted = (state == HALTED);
  assign active = en_pc && (state == RUN);
`else
  assign active = en_pc;
`endif

  assign stack_full  = (depth == FULL_W);
  assign stack_empty = (depth == '0);
  assign pc_result   = pc;
  assign stack_err   = err;
  assign ret_addr    = pc + STEP_W;
  assign wr_idx      = AW'(depth);
  assign rd_idx      = AW'(depth - DW'(1));

  always_comb begin
    pc_next    = pc;
    depth_next = depth;
    err_next   = err;
    push       = 1'b0;
`ifdef PC_SEQUENCER_HALT_EN
    state_next = state;
`endif
    if (active) begin
      case (op)
        OP_SEQ:    pc_next = pc + STEP_W;
        OP_JUMP:   pc_next = in_pc;
        OP_BRANCH: pc_next = take ? pc + in_pc : pc + STEP_W;
        OP_CALL: begin
          if (stack_full) begin
            err_next = 1'b1;
          end else begin
            push       = 1'b1;
            depth_next = depth + DW'(1);
            pc_next    = in_pc;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err_next = 1'b1;
          end else begin
            depth_next = depth - DW'(1);
            pc_next    = stack_mem[rd_idx];
          end
        end
`ifdef PC_SEQUENCER_HALT_EN
        OP_HALT:   state_next = HALTED;
`endif
        default:   pc_next = pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= RESET_W;
      depth <= '0;
      err   <= 1'b0;
`ifdef PC_SEQUENCER_HALT_EN
      state <= RUN;
`endif
    end else begin
      pc    <= pc_next;
      depth <= depth_next;
      err   <= err_next;
`ifdef PC_SEQUENCER_HALT_EN
      state <= state_next;
`endif
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  localparam int WIDTH = 16;

  localparam logic [2:0] SEQ    = 3'b000;
  localparam logic [2:0] JUMP   = 3'b001;
  localparam logic [2:0] BRANCH = 3'b010;
  localparam logic [2:0] CALL   = 3'b011;
  localparam logic [2:0] RET    = 3'b100;
  localparam logic [2:0] HALT   = 3'b101;
  localparam logic [2:0] RSV7   = 3'b111;

  logic             clk = 1'b0;
  logic             reset;
  logic             en_pc;
  logic [2:0]       op;
  logic [WIDTH-1:0] in_pc;
  logic             take;
  logic [WIDTH-1:0] pc_result;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;
`ifdef PC_SEQUENCER_HALT_EN
  logic             halted;
`endif

  int check_count = 0;
  int pass_count  = 0;

  pc_sequencer #(
    .WIDTH(WIDTH), .STEP(1), .RESET_VEC(0), .STACK_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en_pc(en_pc),
    .op(op),
    .in_pc(in_pc),
    .take(take),
    .pc_result(pc_result),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
`ifdef PC_SEQUENCER_HALT_EN
    .halted(halted),
`endif
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst_n, input logic en, input logic [2:0] o,
                               input logic [WIDTH-1:0] target, input logic tk);
    reset = rst_n;
    en_pc = en;
    op    = o;
    in_pc = target;
    take  = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
  endtask

  initial begin
    reset = 1'b0; en_pc = 1'b1; op = SEQ; in_pc = '0; take = 1'b0;

    applyStimulus(1'b0, 1'b1, SEQ, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("reset_pc", pc_result, 16'h0000);
    checkOutput("reset_empty", {15'd0, stack_empty}, 16'd1);
    checkOutput("reset_full", {15'd0, stack_full}, 16'd0);
    checkOutput("reset_err", {15'd0, stack_err}, 16'd0);

    applyStimulus(1'b1, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("seq1", pc_result, 16'h0001);
    applyStimulus(1'b1, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("seq2", pc_result, 16'h0002);
    applyStimulus(1'b1, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("seq3", pc_result, 16'h0003);

    applyStimulus(1'b1, 1'b1, JUMP, 16'hFFFE, 1'b0);
    checkOutput("jump_fffe", pc_result, 16'hFFFE);
    applyStimulus(1'b1, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("seq_ffff", pc_result, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("seq_wrap", pc_result, 16'h0000);

    applyStimulus(1'b1, 1'b1, JUMP, 16'h0010, 1'b0);
    applyStimulus(1'b1, 1'b1, BRANCH, 16'hFFFC, 1'b1);
    checkOutput("branch_taken", pc_result, 16'h000C);
    applyStimulus(1'b1, 1'b1, BRANCH, 16'hFFFC, 1'b0);
    checkOutput("branch_not_taken", pc_result, 16'h000D);
    applyStimulus(1'b1, 1'b0, JUMP, 16'h1234, 1'b1);
    checkOutput("hold1", pc_result, 16'h000D);
    applyStimulus(1'b1, 1'b0, CALL, 16'h1234, 1'b1);
    checkOutput("hold2", pc_result, 16'h000D);
    checkOutput("hold_empty", {15'd0, stack_empty}, 16'd1);

    applyStimulus(1'b1, 1'b1, JUMP, 16'h0020, 1'b0);
    applyStimulus(1'b1, 1'b1, CALL, 16'h0100, 1'b0);
    checkOutput("call1", pc_result, 16'h0100);
    applyStimulus(1'b1, 1'b1, CALL, 16'h0200, 1'b0);
    checkOutput("call2", pc_result, 16'h0200);
    checkOutput("call2_empty", {15'd0, stack_empty}, 16'd0);
    applyStimulus(1'b1, 1'b1, RET, 16'h0000, 1'b0);
    checkOutput("ret1", pc_result, 16'h0101);
    applyStimulus(1'b1, 1'b1, RET, 16'h0000, 1'b0);
    checkOutput("ret2", pc_result, 16'h0021);
    checkOutput("ret2_empty", {15'd0, stack_empty}, 16'd1);
    checkOutput("ret2_err", {15'd0, stack_err}, 16'd0);

    // Return addresses pushed: 0x0022, 0x0011, 0x0021, 0x0031.
    applyStimulus(1'b1, 1'b1, CALL, 16'h0010, 1'b0);
    applyStimulus(1'b1, 1'b1, CALL, 16'h0020, 1'b0);
    applyStimulus(1'b1, 1'b1, CALL, 16'h0030, 1'b0);
    checkOutput("ovf_call3_full", {15'd0, stack_full}, 16'd0);
    applyStimulus(1'b1, 1'b1, CALL, 16'h0040, 1'b0);
    checkOutput("ovf_call4_pc", pc_result, 16'h0040);
    checkOutput("ovf_call4_full", {15'd0, stack_full}, 16'd1);
    checkOutput("ovf_call4_err", {15'd0, stack_err}, 16'd0);
    applyStimulus(1'b1, 1'b1, CALL, 16'h0050, 1'b0);
    checkOutput("ovf_call5_pc", pc_result, 16'h0040);
    checkOutput("ovf_call5_err", {15'd0, stack_err}, 16'd1);
    applyStimulus(1'b1, 1'b1, RET, 16'h0000, 1'b0);
    checkOutput("ovf_ret1", pc_result, 16'h0031);
    applyStimulus(1'b1, 1'b1, RET, 16'h0000, 1'b0);
    checkOutput("ovf_ret2", pc_result, 16'h0021);
    applyStimulus(1'b1, 1'b1, RET, 16'h0000, 1'b0);
    checkOutput("ovf_ret3", pc_result, 16'h0011);
    applyStimulus(1'b1, 1'b1, RET, 16'h0000, 1'b0);
    checkOutput("ovf_ret4", pc_result, 16'h0022);
    checkOutput("ovf_ret4_empty", {15'd0, stack_empty}, 16'd1);
    checkOutput("ovf_err_sticky", {15'd0, stack_err}, 16'd1);

    applyStimulus(1'b0, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("rst_clear_err", {15'd0, stack_err}, 16'd0);
    applyStimulus(1'b1, 1'b1, JUMP, 16'h0033, 1'b0);
    applyStimulus(1'b1, 1'b1, RET, 16'h0000, 1'b0);
    checkOutput("udf_pc", pc_result, 16'h0033);
    checkOutput("udf_err", {15'd0, stack_err}, 16'd1);
    applyStimulus(1'b1, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("udf_seq_pc", pc_result, 16'h0034);
    checkOutput("udf_seq_err", {15'd0, stack_err}, 16'd1);
    applyStimulus(1'b1, 1'b1, CALL, 16'h0500, 1'b0);
    checkOutput("mid_call_pc", pc_result, 16'h0500);
    applyStimulus(1'b0, 1'b1, CALL, 16'h0600, 1'b0);
    checkOutput("mid_rst_pc", pc_result, 16'h0000);
    checkOutput("mid_rst_empty", {15'd0, stack_empty}, 16'd1);
    checkOutput("mid_rst_err", {15'd0, stack_err}, 16'd0);

    applyStimulus(1'b1, 1'b1, JUMP, 16'h0042, 1'b0);
    applyStimulus(1'b1, 1'b1, RSV7, 16'h0999, 1'b1);
    checkOutput("rsv7_pc", pc_result, 16'h0042);
    checkOutput("rsv7_err", {15'd0, stack_err}, 16'd0);

`ifdef PC_SEQUENCER_HALT_EN
    checkOutput("halt_pre", {15'd0, halted}, 16'd0);
    applyStimulus(1'b1, 1'b1, HALT, 16'h0000, 1'b0);
    checkOutput("halt_flag", {15'd0, halted}, 16'd1);
    checkOutput("halt_pc", pc_result, 16'h0042);
    applyStimulus(1'b1, 1'b1, JUMP, 16'h0100, 1'b0);
    checkOutput("halt_jump", pc_result, 16'h0042);
    applyStimulus(1'b1, 1'b1, CALL, 16'h0200, 1'b0);
    checkOutput("halt_call", pc_result, 16'h0042);
    checkOutput("halt_call_empty", {15'd0, stack_empty}, 16'd1);
    applyStimulus(1'b1, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("halt_seq", pc_result, 16'h0042);
    applyStimulus(1'b0, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("halt_rst_flag", {15'd0, halted}, 16'd0);
    checkOutput("halt_rst_pc", pc_result, 16'h0000);
`else
    applyStimulus(1'b1, 1'b1, HALT, 16'h0777, 1'b1);
    checkOutput("rsv5_pc", pc_result, 16'h0042);
    applyStimulus(1'b1, 1'b1, SEQ, 16'h0000, 1'b0);
    checkOutput("rsv5_then_seq", pc_result, 16'h0043);
`endif

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
